// File: rtl/uart_rx_top.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : uart_rx_top                                              |
// | Description : 16550-style UART receiver. It oversamples rx on a 16x    |
// |               baud enable and recovers the start, data, parity and     |
// |               stop bits, then flags parity, framing and break errors.  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module uart_rx_top #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  input  logic [1:0] wls,
  output logic       push,
  output logic [7:0] dout,
  output logic       pe,
  output logic       fe,
  output logic       bi
);

  localparam int c_TICK_W = $clog2(OVERSAMPLE);
  localparam logic [c_TICK_W-1:0] c_TICK_MID = c_TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_END = c_TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_TICK_W-1:0]    r_tick;
  logic [2:0]             r_bit;
  logic [7:0]             r_shift;
  logic                   r_armed;
  logic                   r_par_bit;
  logic                   r_pen;
  logic                   r_eps;
  logic                   r_sticky;
  logic [1:0]             r_wls;

  logic       w_rx_s;
  logic [7:0] w_mask;
  logic [7:0] w_data;
  logic       w_exp_par;
  logic [2:0] w_last_bit;

  assign w_rx_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_mask     = 8'hFF >> (2'd3 - r_wls);
    w_data     = r_shift & w_mask;
    w_last_bit = {1'b0, r_wls} + 3'd4;
    // Stick parity forces the parity bit to the complement of eps, regardless of data
    if (r_sticky)
      w_exp_par = ~r_eps;
    else if (r_eps)
      w_exp_par = ^w_data;
    else
      w_exp_par = ~^w_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync    <= '1;
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_armed   <= 1'b0;
      r_par_bit <= 1'b0;
      r_pen     <= 1'b0;
      r_eps     <= 1'b0;
      r_sticky  <= 1'b0;
      r_wls     <= 2'b00;
      push      <= 1'b0;
      dout      <= 8'h00;
      pe        <= 1'b0;
      fe        <= 1'b0;
      bi        <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
      push   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rx_s)
            r_armed <= 1'b1;
          // Arming requires a high line first, so a held break cannot retrigger
          if (r_armed && !w_rx_s) begin
            r_state  <= S_START;
            r_tick   <= '0;
            r_pen    <= pen;
            r_eps    <= eps;
            r_sticky <= sticky_parity;
            r_wls    <= wls;
          end
        end
        S_START: begin
          if (baud_pulse) begin
            if (r_tick == c_TICK_MID) begin
              r_tick <= '0;
              r_bit  <= '0;
              r_state <= w_rx_s ? S_IDLE : S_DATA;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (baud_pulse) begin
            if (r_tick == c_TICK_END) begin
              r_tick         <= '0;
              r_shift[r_bit] <= w_rx_s;
              if (r_bit == w_last_bit)
                r_state <= r_pen ? S_PARITY : S_STOP;
              else
                r_bit <= r_bit + 1'b1;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (baud_pulse) begin
            if (r_tick == c_TICK_END) begin
              r_tick    <= '0;
              r_par_bit <= w_rx_s;
              r_state   <= S_STOP;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (baud_pulse) begin
            if (r_tick == c_TICK_END) begin
              r_tick  <= '0;
              r_state <= S_IDLE;
              r_armed <= 1'b0;
              push    <= 1'b1;
              dout    <= w_data;
              pe      <= r_pen && (r_par_bit != w_exp_par);
              fe      <= ~w_rx_s;
              bi      <= ~w_rx_s && (w_data == 8'h00) && (!r_pen || !r_par_bit);
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tick  <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_top.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_uart_rx_top                                           |
// | Description : Self-checking bench for uart_rx_top with a frame-level   |
// |               reference model and directed plus random frames.         |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_uart_rx_top;

  localparam int c_BIT_CLKS = 96;

  logic       clk;
  logic       rst;
  logic       baud_pulse;
  logic       rx;
  logic       pen;
  logic       eps;
  logic       sticky_parity;
  logic [1:0] wls;
  logic       push;
  logic [7:0] dout;
  logic       pe;
  logic       fe;
  logic       bi;

  int n_vec;
  int n_err;
  logic [10:0] r_pushq[$];

  uart_rx_top dut (
    .clk          (clk),
    .rst          (rst),
    .baud_pulse   (baud_pulse),
    .rx           (rx),
    .pen          (pen),
    .eps          (eps),
    .sticky_parity(sticky_parity),
    .wls          (wls),
    .push         (push),
    .dout         (dout),
    .pe           (pe),
    .fe           (fe),
    .bi           (bi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_pulse = 1'b0;
    forever begin
      repeat (5) @(negedge clk);
      baud_pulse = 1'b1;
      @(negedge clk);
      baud_pulse = 1'b0;
    end
  end

  // Record every push as {bi, fe, pe, dout}
  always @(negedge clk)
    if (push) r_pushq.push_back({bi, fe, pe, dout});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: what a receiver must report for the given line bits
  function automatic logic [10:0] model(input logic [7:0] data, input logic [1:0] w,
                                        input logic p_en, input logic e_ps, input logic stk,
                                        input logic par, input logic stop);
    int         n;
    int         ones;
    logic [7:0] d;
    logic       exp_par;
    logic       e_pe;
    logic       e_fe;
    logic       e_bi;
    n    = int'(w) + 5;
    d    = data & 8'((1 << n) - 1);
    ones = $countones(d);
    if (stk)       exp_par = !e_ps;
    else if (e_ps) exp_par = (ones % 2 == 1);
    else           exp_par = (ones % 2 == 0);
    e_pe = p_en && (par != exp_par);
    e_fe = (stop == 1'b0);
    e_bi = e_fe && (d == 8'h00) && (!p_en || par == 1'b0);
    return {e_bi, e_fe, e_pe, d};
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    repeat (c_BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] data, input logic [1:0] w,
                            input logic p_en, input logic e_ps, input logic stk,
                            input logic par, input logic stop);
    logic [10:0] exp;
    logic [10:0] got;
    wls = w; pen = p_en; eps = e_ps; sticky_parity = stk;
    send_bit(1'b0);
    for (int i = 0; i < int'(w) + 5; i++) send_bit(data[i]);
    if (p_en) send_bit(par);
    send_bit(stop);
    send_bit(1'b1);
    send_bit(1'b1);
    exp = model(data, w, p_en, e_ps, stk, par, stop);
    chk({tag, ".npush"}, r_pushq.size(), 1);
    if (r_pushq.size() > 0) begin
      got = r_pushq.pop_front();
      chk({tag, ".dout"}, got[7:0], exp[7:0]);
      chk({tag, ".pe"},   got[8],   exp[8]);
      chk({tag, ".fe"},   got[9],   exp[9]);
      chk({tag, ".bi"},   got[10],  exp[10]);
    end
    r_pushq.delete();
  endtask

  initial begin
    logic [7:0]  d;
    logic [1:0]  w;
    logic        p, e, s, par, stop;
    logic [10:0] got;
    n_vec = 0; n_err = 0;
    rst = 1'b0; rx = 1'b1; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0; wls = 2'b11;
    repeat (5) @(negedge clk);
    chk("rst.push", push, 0);
    chk("rst.out", {bi, fe, pe, dout}, 11'h000);
    rst = 1'b1;
    repeat (2 * c_BIT_CLKS) @(negedge clk);

    send_frame("T1", 8'h13, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame("T2", 8'h13, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame("T3", 8'h0D, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("T3.hold", dout, 8'h0D);

    // Break: line low for 30 bit times must give exactly one frame
    wls = 2'b11; pen = 1'b1; eps = 1'b1; sticky_parity = 1'b0;
    rx = 1'b0;
    repeat (30 * c_BIT_CLKS) @(negedge clk);
    chk("T4.npush", r_pushq.size(), 1);
    if (r_pushq.size() > 0) begin
      got = r_pushq.pop_front();
      chk("T4.brk", got, 11'b110_0000_0000);
    end
    r_pushq.delete();
    send_bit(1'b1);
    send_bit(1'b1);
    chk("T4.idle", r_pushq.size(), 0);
    send_frame("T4b", 8'h55, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // Glitch shorter than half a bit
    rx = 1'b0;
    repeat (24) @(negedge clk);
    rx = 1'b1;
    repeat (3 * c_BIT_CLKS) @(negedge clk);
    chk("T5.npush", r_pushq.size(), 0);
    send_frame("T5b", 8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset during data bit 3 of 0xA5
    wls = 2'b11; pen = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("T6.rst", {push, bi, fe, pe, dout}, 12'h000);
    rst = 1'b1;
    rx = 1'b1;
    repeat (3 * c_BIT_CLKS) @(negedge clk);
    chk("T6.npush", r_pushq.size(), 0);
    send_frame("T6b", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    send_frame("T7a", 8'h3C, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame("T7b", 8'h3C, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 30; i++) begin
      d    = 8'($urandom);
      w    = 2'($urandom);
      p    = 1'($urandom);
      e    = 1'($urandom);
      s    = 1'($urandom);
      par  = 1'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      send_frame("RND", d, w, p, e, s, par, stop);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
